// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - single-stage registered bitwise logic unit with accumulator and handshake
// One output register slot; the accumulator holds the last accepted result for chaining.
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               acc_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  output logic               zero,
  output logic               parity,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept) state_nxt = FULL;
      FULL:  if (out_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  assign operand_b = acc_en ? acc : b;

  always_comb begin
    result = '0;
    case (op)
      3'd0: result = a & operand_b;
      3'd1: result = a | operand_b;
      3'd2: result = ~(a & operand_b);
      3'd3: result = ~(a | operand_b);
      3'd4: result = a ^ operand_b;
      3'd5: result = ~(a ^ operand_b);
      3'd6: result = ~a;
      3'd7: result = a;
      default: result = '0;
    endcase
  end

  // zero/parity are registered alongside y so they never lag the result they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y        <= '0;
      zero     <= 1'b1;
      parity   <= 1'b0;
      acc      <= '0;
      op_count <= '0;
    end else if (accept) begin
      y      <= result;
      zero   <= (result == '0);
      parity <= ^result;
      acc    <= result;
      if (op_count != COUNT_MAX) begin
        op_count <= op_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 1..64.
REQ-002 Parameter COUNT_W, default 16: width of the transaction counter; legal range 2..32.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  the operand set on a, b, op, acc_en is valid.
REQ-006 in_ready  output  1  the block accepts the operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; ignored when acc_en=1.
REQ-009 op  input  3  operation select per REQ-014.
REQ-010 acc_en  input  1  replaces operand B with the accumulator.
REQ-011 out_valid  output  1  y, zero and parity hold a result.
REQ-012 out_ready  input  1  the downstream consumer takes the result this cycle.
REQ-013 y  output  WIDTH  registered result; zero  output  1  y==0; parity  output  1  XOR-reduction of y; op_count  output  COUNT_W  accepted-transaction count.

Function
REQ-014 Op encoding, bitwise across WIDTH bits, with B' = (acc_en ? acc : b):
- 0 = AND (a & B')
- 1 = OR
- 2 = NAND
- 3 = NOR
- 4 = XOR
- 5 = XNOR
- 6 = NOT a
- 7 = pass a
REQ-015 Two-state control FSM:
- EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY->FULL on accept.
- FULL->EMPTY on out_ready with no accept.
- FULL stays FULL on an accept or on stall.
REQ-016 in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
REQ-017 On accept, y, zero, parity and out_valid=1 update at the next rising edge (latency 1 cycle).
REQ-018 Full throughput: with in_valid=1 and out_ready=1 held, one result is produced every cycle.
REQ-019 Stall: while out_valid=1 and out_ready=0, y, zero, parity and out_valid hold stable and in_ready=0.
REQ-020 Simultaneous out_ready and accept in FULL: the old result is consumed and the new one is loaded in the same edge; out_valid stays 1.
REQ-021 Accumulator acc (WIDTH bits, internal) loads the computed result on every accept, regardless of acc_en.
REQ-022 Accumulator chaining: acc_en on back-to-back accepts uses the result of the immediately preceding accept.
REQ-023 acc is not exposed on any port.
REQ-024 op_count increments by 1 on each accept.
REQ-025 op_count saturates at 2^COUNT_W-1 and does not wrap.
REQ-026 Inputs are ignored when in_valid=0 or in_ready=0; no state changes in that case except out_valid clearing per REQ-015.
REQ-027 zero and parity are registered with y and always describe the current y.
REQ-028 No X propagation: all outputs are driven from reset onward.

Reset
REQ-029 While rst=1: out_valid=0, y=0, zero=1, parity=0, acc=0, op_count=0, FSM=EMPTY; in_ready therefore reads 1.
REQ-030 Reset asserted mid-transaction discards the pending result immediately, without waiting for a clock edge.
REQ-031 The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-032 Sweep: WIDTH=8, out_ready=1, a=8'hC5, b=8'h3A, op=0..7 on consecutive cycles -> y is 00, FF, FF, 00, FF, 00, 3A, C5 one cycle after each input; op_count=8.
REQ-033 Backpressure: accept a=8'hF0, b=8'h0F, op=4, then hold out_ready=0 for 3 cycles with in_valid=1 -> y=FF stable, in_ready=0, parity=0, zero=0, op_count=1.
REQ-034 Accumulate: a=8'h0F, b=8'h00, op=1, then a=8'hF0, op=4, acc_en=1 -> second y=FF; then a=8'hFF, op=0, acc_en=1 -> y=FF, then op=5 with a=8'h00, acc_en=1 -> y=00, zero=1.
REQ-035 Saturation: COUNT_W=2, seven accepts -> op_count reads 1, 2, 3, 3, 3, 3, 3.
REQ-036 Async reset: assert rst mid-cycle while out_valid=1 -> out_valid, y and op_count are 0 before the next edge; the next accept after release yields the correct result with acc=0.
REQ-037 Random: 10k cycles with random in_valid, out_ready and operands against a reference model -> no lost, duplicated or reordered results.
